// File: rtl/pipe_adder_n.sv
// pipe_adder_n: pipelined ripple-carry adder/subtractor.
//   A WIDTH-bit add is split into STAGES = WIDTH/STAGE_W chunks, one chunk
//   per pipeline stage, with the inter-stage carry always registered.
//   S = A + B + CIN (sub_i = 0) or S = A - B - CIN (sub_i = 1).
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operand set presented     in_ready_o   operands accepted
//   a_i, b_i     operands                  cin_i        carry/borrow in
//   sub_i        1 = subtract
//   out_valid_o  result valid              out_ready_i  result consumed
//   s_o          result (mod 2^WIDTH)      cout_o       carry out (1 = no borrow)
//   ovf_o        two's-complement overflow
module pipe_adder_n #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int STAGES = WIDTH / STAGE_W;
  localparam int LAST   = STAGES - 1;

  // Per-stage registers. a/b carry the operand skew (upper chunks still to
  // be added), s accumulates the result deskew (lower chunks already done).
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] v_q, v_d;
  logic              ovf_q, ovf_d;

  // Stage inputs: the port for stage 0, the previous stage register otherwise.
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;
  logic [STAGE_W:0]  chunk [STAGES];

  logic adv;

  // Whole pipeline moves together; a held result stalls every stage.
  assign adv = !v_q[LAST] || out_ready_i;

  always_comb begin
    a_src[0] = a_i;
    b_src[0] = b_i ^ {WIDTH{sub_i}};
    s_src[0] = '0;
    c_src[0] = cin_i ^ sub_i;
    v_src[0] = in_valid_i;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_src[k][k*STAGE_W +: STAGE_W]}
               + {1'b0, b_src[k][k*STAGE_W +: STAGE_W]}
               + {{STAGE_W{1'b0}}, c_src[k]};
      a_d[k] = a_src[k];
      b_d[k] = b_src[k];
      s_d[k] = s_src[k];
      s_d[k][k*STAGE_W +: STAGE_W] = chunk[k][STAGE_W-1:0];
      c_d[k] = chunk[k][STAGE_W];
      v_d[k] = v_src[k];
    end

    // Same-sign operands giving an opposite-sign sum is exactly
    // carry-into-MSB xor carry-out-of-MSB.
    ovf_d = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
            (s_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

  assign in_ready_o  = adv;
  assign out_valid_o = v_q[LAST];
  assign s_o         = s_q[LAST];
  assign cout_o      = c_q[LAST];
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_n.sv
// Scoreboard bench for pipe_adder_n (16/4 main instance, 4/1 legacy instance).
module tb_pipe_adder_n;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int ST = W / SW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  a, b, s;

  logic          in_valid4, in_ready4, cin4, sub4, out_valid4, cout4, ovf4;
  logic [3:0]    a4, b4, s4;

  pipe_adder_n #(.WIDTH(W), .STAGE_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .sub_i(sub),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .s_o(s), .cout_o(cout), .ovf_o(ovf)
  );

  pipe_adder_n #(.WIDTH(4), .STAGE_W(1)) dut4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid4), .in_ready_o(in_ready4),
    .a_i(a4), .b_i(b4), .cin_i(cin4), .sub_i(sub4),
    .out_valid_o(out_valid4), .out_ready_i(1'b1),
    .s_o(s4), .cout_o(cout4), .ovf_o(ovf4)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
    bit           lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   rand_bp  = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Independent reference: integer arithmetic, signed range test for overflow.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mcin, input logic msub,
                       output logic [W-1:0] ms, output logic mc, output logic mo);
    int ua, ub, sa, sb, r, sr;
    ua = int'(ma);
    ub = int'(mb);
    sa = $signed(ma);
    sb = $signed(mb);
    if (!msub) begin
      r  = ua + ub + int'(mcin);
      mc = (r > 65535);
      sr = sa + sb + int'(mcin);
    end else begin
      r  = ua - ub - int'(mcin);
      mc = (ua >= ub + int'(mcin));
      sr = sa - sb - int'(mcin);
    end
    ms = r[W-1:0];
    mo = (sr > 32767) || (sr < -32768);
  endtask

  // Backpressure generator.
  always @(posedge clk) begin
    #1;
    out_ready = rand_bp ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  // Monitor: compares every consumed result and checks the stall rules.
  logic         stall_prev = 1'b0;
  logic [W-1:0] s_hold;
  logic         c_hold, o_hold;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_s", s, s_hold);
        chk("hold_cout", cout, c_hold);
        chk("hold_ovf", ovf, o_hold);
      end
      chk("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result_valid", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("s", s, e.s);
          chk("cout", cout, e.c);
          chk("ovf", ovf, e.o);
          if (e.lat) chk("latency", cyc - e.cyc, ST);
        end
      end
      stall_prev = out_valid && !out_ready;
      s_hold = s;
      c_hold = cout;
      o_hold = ovf;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tcin, input logic tsub,
                      input logic [W-1:0] es, input logic ec, input logic eo,
                      input bit lat);
    bit ok;
    ok = 0;
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{s: es, c: ec, o: eo, cyc: cyc, lat: lat});
        ok = 1;
        break;
      end
    end
    if (!ok) chk("accept_timeout_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] ra, rb, rs;
  logic         rcin, rsub, rc, ro;

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;

    // Reset held two cycles with IN_VALID high: nothing accepted.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_s", s, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    // Directed vectors, back to back.
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
    send(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);
    send(16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0, 1);
    send(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, 1);
    in_valid = 1'b0;
    drain();

    // Legacy 4-bit chain: 0xF + 0x9.
    a4 = 4'hF; b4 = 4'h9; in_valid4 = 1'b1;
    @(negedge clk);
    chk("leg_in_ready", in_ready4, 1'b1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("leg_early_valid", out_valid4, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("leg_valid", out_valid4, 1'b1);
    chk("leg_s", s4, 4'h8);
    chk("leg_cout", cout4, 1'b1);
    chk("leg_ovf", ovf4, 1'b0);
    @(posedge clk);
    #1;

    // Streaming with random backpressure.
    rand_bp = 1;
    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rcin = 1'($urandom_range(1, 0)); rsub = 1'($urandom_range(1, 0));
      model(ra, rb, rcin, rsub, rs, rc, ro);
      send(ra, rb, rcin, rsub, rs, rc, ro, 0);
    end
    in_valid = 1'b0;
    drain();
    rand_bp = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset with three operations in flight.
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0);
    send(16'h4444, 16'h1111, 1'b0, 1'b1, 16'h3333, 1'b1, 1'b0, 0);
    send(16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", out_valid, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1);
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
